// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I core's ID/EX issue logic.
//   XLEN / REG_AW : datapath width and register-index width.
//   ALU_*         : 4-bit ALU opcodes, encoded as {instr bit30, funct3}.
//   opsel_e       : operand class selected by decode.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;

  typedef enum logic [1:0] {
    OPSEL_OP    = 2'b00,  // a = rs1, b = rs2
    OPSEL_IMM   = 2'b01,  // a = rs1, b = imm
    OPSEL_ADDR  = 2'b10,  // a = rs1, b = imm, rs2 carried as store data
    OPSEL_PCREL = 2'b11   // a = pc,  b = imm
  } opsel_e;

  // Set-less-than funct3 values have no ALU opcode and are flagged as unsupported.
  function automatic logic is_slt_funct3(input logic [2:0] funct3);
    return (funct3 == 3'b010) || (funct3 == 3'b011);
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Operand forwarding for one source register of the ID/EX stage.
//   held_data      : value currently held for this source
//   rs_addr        : source register index
//   mem_fwd_*      : MEM-stage writeback port (newest producer)
//   wb_fwd_*       : WB-stage writeback port
//   fwd_data       : resolved operand value (x0 always reads 0)
//   load_hazard    : MEM producer matches but is a load, so its data is not ready
module fwd_mux
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0]   held_data,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic              mem_fwd_valid,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              mem_fwd_is_load,
  input  logic              wb_fwd_valid,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic [XLEN-1:0]   fwd_data,
  output logic              load_hazard
);

  logic rs_nonzero;
  logic mem_hit;
  logic wb_hit;

  always_comb begin
    rs_nonzero  = (rs_addr != '0);
    mem_hit     = mem_fwd_valid && (mem_fwd_rd == rs_addr) && rs_nonzero;
    wb_hit      = wb_fwd_valid && (wb_fwd_rd == rs_addr) && rs_nonzero;
    load_hazard = mem_hit && mem_fwd_is_load;
    // MEM holds the younger producer, so it wins over WB.
    if (!rs_nonzero)  fwd_data = '0;
    else if (mem_hit) fwd_data = mem_fwd_data;
    else if (wb_hit)  fwd_data = wb_fwd_data;
    else              fwd_data = held_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline stage of the RV32I core, directly upstream of the execute ALU.
// Holds one decoded instruction, resolves MEM/WB forwarding for rs1/rs2,
// stalls on load-use hazards and presents ALU operands plus opcode.
//   in_*            : decoded instruction from ID (valid/ready)
//   flush           : kill the held instruction and any arriving one
//   mem_fwd_*/wb_*  : writeback ports of the MEM and WB stages
//   out_valid/ready : handshake toward EX
//   alu_a/alu_b     : combinational operands (held state + forwarding)
//   alu_op, out_rd, out_is_load, out_unsupported : registered at capture
//   out_store_data  : forwarded rs2 value
//
// Handshake: a transfer happens on a cycle where valid && ready are both high.
// The producer keeps its payload stable while valid && !ready; ready may depend
// combinationally on the consumer's ready (in_ready follows out_ready) but valid
// never depends on the same interface's ready.
module alu_issue_stage
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [2:0]        in_funct3,
  input  logic              in_b30,
  input  logic [1:0]        in_op_sel,
  input  logic              in_is_load,
  input  logic              flush,
  input  logic              mem_fwd_valid,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              mem_fwd_is_load,
  input  logic              wb_fwd_valid,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_is_load,
  output logic [XLEN-1:0]   out_store_data,
  output logic              out_unsupported
);

  // Held instruction state.
  logic              reg_valid_q,   reg_valid_d;
  logic [XLEN-1:0]   pc_q,          pc_d;
  logic [XLEN-1:0]   rs1_data_q,    rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q,    rs2_data_d;
  logic [REG_AW-1:0] rs1_addr_q,    rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q,    rs2_addr_d;
  logic [REG_AW-1:0] rd_q,          rd_d;
  logic [XLEN-1:0]   imm_q,         imm_d;
  opsel_e            op_sel_q,      op_sel_d;
  logic [3:0]        alu_op_q,      alu_op_d;
  logic              is_load_q,     is_load_d;
  logic              unsupported_q, unsupported_d;

  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic            rs1_hz,  rs2_hz;
  logic            use_rs1, use_rs2;
  logic            hazard;
  logic            fire_out;
  logic            capture;
  logic [3:0]      dec_op;
  logic            dec_unsup;

  fwd_mux u_fwd_rs1 (
    .held_data       (rs1_data_q),
    .rs_addr         (rs1_addr_q),
    .mem_fwd_valid   (mem_fwd_valid),
    .mem_fwd_rd      (mem_fwd_rd),
    .mem_fwd_data    (mem_fwd_data),
    .mem_fwd_is_load (mem_fwd_is_load),
    .wb_fwd_valid    (wb_fwd_valid),
    .wb_fwd_rd       (wb_fwd_rd),
    .wb_fwd_data     (wb_fwd_data),
    .fwd_data        (rs1_fwd),
    .load_hazard     (rs1_hz)
  );

  fwd_mux u_fwd_rs2 (
    .held_data       (rs2_data_q),
    .rs_addr         (rs2_addr_q),
    .mem_fwd_valid   (mem_fwd_valid),
    .mem_fwd_rd      (mem_fwd_rd),
    .mem_fwd_data    (mem_fwd_data),
    .mem_fwd_is_load (mem_fwd_is_load),
    .wb_fwd_valid    (wb_fwd_valid),
    .wb_fwd_rd       (wb_fwd_rd),
    .wb_fwd_data     (wb_fwd_data),
    .fwd_data        (rs2_fwd),
    .load_hazard     (rs2_hz)
  );

  // Handshake and hazard. Only sources the class actually consumes can stall;
  // ADDR consumes rs2 as store data.
  always_comb begin
    use_rs1  = (op_sel_q != OPSEL_PCREL);
    use_rs2  = (op_sel_q == OPSEL_OP) || (op_sel_q == OPSEL_ADDR);
    hazard   = reg_valid_q && ((use_rs1 && rs1_hz) || (use_rs2 && rs2_hz));
    out_valid = reg_valid_q && !hazard;
    fire_out = out_valid && out_ready;
    in_ready = !reg_valid_q || fire_out;
    capture  = in_valid && in_ready && !flush;
  end

  // Opcode decode from the arriving instruction. OP-IMM only honours bit30
  // for the shift-right pair, so an ADDI with imm[10]=1 stays an ADD.
  always_comb begin
    dec_op    = ALU_ADD;
    dec_unsup = 1'b0;
    case (in_op_sel)
      OPSEL_OP: begin
        if (is_slt_funct3(in_funct3)) dec_unsup = 1'b1;
        else                          dec_op    = {in_b30, in_funct3};
      end
      OPSEL_IMM: begin
        if (is_slt_funct3(in_funct3)) dec_unsup = 1'b1;
        else dec_op = {in_b30 && (in_funct3 == 3'b101), in_funct3};
      end
      default: begin
        dec_op    = ALU_ADD;
        dec_unsup = 1'b0;
      end
    endcase
  end

  // Next-state. While an instruction waits (stall or backpressure) its source
  // data tracks the forwarded values so a producer leaving WB is not lost.
  always_comb begin
    reg_valid_d   = reg_valid_q;
    pc_d          = pc_q;
    rs1_data_d    = rs1_data_q;
    rs2_data_d    = rs2_data_q;
    rs1_addr_d    = rs1_addr_q;
    rs2_addr_d    = rs2_addr_q;
    rd_d          = rd_q;
    imm_d         = imm_q;
    op_sel_d      = op_sel_q;
    alu_op_d      = alu_op_q;
    is_load_d     = is_load_q;
    unsupported_d = unsupported_q;

    if (reg_valid_q && !fire_out) begin
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
    end

    if (flush) begin
      reg_valid_d = 1'b0;
    end else if (capture) begin
      reg_valid_d   = 1'b1;
      pc_d          = in_pc;
      rs1_data_d    = in_rs1_data;
      rs2_data_d    = in_rs2_data;
      rs1_addr_d    = in_rs1_addr;
      rs2_addr_d    = in_rs2_addr;
      rd_d          = in_rd;
      imm_d         = in_imm;
      op_sel_d      = opsel_e'(in_op_sel);
      alu_op_d      = dec_op;
      is_load_d     = in_is_load;
      unsupported_d = dec_unsup;
    end else if (fire_out) begin
      reg_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_valid_q   <= 1'b0;
      pc_q          <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      op_sel_q      <= OPSEL_OP;
      alu_op_q      <= ALU_ADD;
      is_load_q     <= 1'b0;
      unsupported_q <= 1'b0;
    end else begin
      reg_valid_q   <= reg_valid_d;
      pc_q          <= pc_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rd_q          <= rd_d;
      imm_q         <= imm_d;
      op_sel_q      <= op_sel_d;
      alu_op_q      <= alu_op_d;
      is_load_q     <= is_load_d;
      unsupported_q <= unsupported_d;
    end
  end

  // Operand selection on held state plus live forwarding.
  always_comb begin
    alu_a = rs1_fwd;
    alu_b = imm_q;
    case (op_sel_q)
      OPSEL_OP:    alu_b = rs2_fwd;
      OPSEL_PCREL: alu_a = pc_q;
      default:     alu_b = imm_q;
    endcase
    out_store_data = rs2_fwd;
  end

  assign alu_op          = alu_op_q;
  assign out_rd          = rd_q;
  assign out_is_load     = is_load_q;
  assign out_unsupported = unsupported_q;

endmodule
